// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream controller.
//   sample_t        : one codec sample (signed, bit-exact passthrough)
//   stream_state_e  : codec handshake sequencer states
//   DROP_MAX        : saturation value of the drop counter
//   sat_inc8        : saturating 8-bit increment helper
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } stream_state_e;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == DROP_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the wave drawer.
//   clk, reset_n : clock, async active-low reset
//   push, push_data : write request and data (accepted when not full, or
//                     when a pop frees a slot in the same cycle)
//   pop          : consume the head (ignored while empty)
//   head         : current head entry, valid whenever empty is low
//   empty, full  : occupancy flags
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array and read/write pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Codec handshake sequencer with loopback, mute, channel select,
// decimation and a drawer-side sample FIFO.
//   clk, reset_n               : clock, async active-low reset
//   enable                     : allow new codec transfers
//   sel_right, mute            : buffered channel select, DAC mute
//   read_ready, write_ready    : codec handshake flags
//   readdata_left/right        : ADC sample pair
//   read, write                : one-cycle codec pop/push strobes
//   writedata_left/right       : DAC sample pair (loopback or zero)
//   sample_valid/data/ready    : FWFT drawer stream
//   overflow, drop_count       : sticky drop flag, saturating drop count
//   xfer_count                 : completed transfers, wrapping
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    parameter int DECIM = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sel_right,
    input  logic             mute,
    input  logic             read_ready,
    input  logic             write_ready,
    input  logic [WIDTH-1:0] readdata_left,
    input  logic [WIDTH-1:0] readdata_right,
    output logic             read,
    output logic             write,
    output logic [WIDTH-1:0] writedata_left,
    output logic [WIDTH-1:0] writedata_right,
    output logic             sample_valid,
    output logic [WIDTH-1:0] sample_data,
    input  logic             sample_ready,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic [15:0]      xfer_count
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] DCNT_LAST = CW'(DECIM - 1);

    stream_state_e    state_q, state_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] wdl_q, wdl_d;
    logic [WIDTH-1:0] wdr_q, wdr_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             fwd_q, fwd_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [15:0]      xfer_q, xfer_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;

    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             drop_s;

    assign pop_s  = sample_ready & ~empty_s;
    // fwd_q is high only during GAP, so it doubles as the push strobe.
    assign drop_s = fwd_q & full_s & ~pop_s;

    // Next-state, strobe, capture, decimation and counter logic.
    always_comb begin
        state_d = state_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        wdl_d   = wdl_q;
        wdr_d   = wdr_q;
        cap_d   = cap_q;
        fwd_d   = 1'b0;
        dcnt_d  = dcnt_q;
        xfer_d  = xfer_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                // Ready flags are only sampled here; XFER never re-checks them.
                if (enable && read_ready && write_ready) begin
                    state_d = XFER;
                    read_d  = 1'b1;
                    write_d = 1'b1;
                    cap_d   = sel_right ? readdata_right : readdata_left;
                    if (mute) begin
                        wdl_d = '0;
                        wdr_d = '0;
                    end else begin
                        wdl_d = readdata_left;
                        wdr_d = readdata_right;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                state_d = GAP;
                xfer_d  = xfer_q + 16'd1;
                if (dcnt_q == DCNT_LAST) begin
                    fwd_d  = 1'b1;
                    dcnt_d = '0;
                end else begin
                    fwd_d  = 1'b0;
                    dcnt_d = dcnt_q + CW'(1'b1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop_s) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc8(drop_q);
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdl_q   <= '0;
            wdr_q   <= '0;
            cap_q   <= '0;
            fwd_q   <= 1'b0;
            dcnt_q  <= '0;
            xfer_q  <= 16'd0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdl_q   <= wdl_d;
            wdr_q   <= wdr_d;
            cap_q   <= cap_d;
            fwd_q   <= fwd_d;
            dcnt_q  <= dcnt_d;
            xfer_q  <= xfer_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fwd_q),
        .push_data (cap_q),
        .pop       (pop_s),
        .head      (sample_data),
        .empty     (empty_s),
        .full      (full_s)
    );

    assign read            = read_q;
    assign write           = write_q;
    assign writedata_left  = wdl_q;
    assign writedata_right = wdr_q;
    assign sample_valid    = ~empty_s;
    assign overflow        = ovf_q;
    assign drop_count      = drop_q;
    assign xfer_count      = xfer_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
module tb_audio_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable, sel_right, mute, read_ready, write_ready;
    logic [23:0] readdata_left, readdata_right;
    logic        ready_a, ready_b;

    logic        a_read, a_write, a_valid, a_ovf;
    logic [23:0] a_wdl, a_wdr, a_data;
    logic [7:0]  a_drop;
    logic [15:0] a_xfer;

    logic        b_read, b_write, b_valid, b_ovf;
    logic [23:0] b_wdl, b_wdr, b_data;
    logic [7:0]  b_drop;
    logic [15:0] b_xfer;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        mon_en = 1'b0;
    logic [23:0] mon_q [$];

    always #5 clk = ~clk;

    audio_stream_ctrl #(.WIDTH(24), .DEPTH(8), .DECIM(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sel_right(sel_right),
        .mute(mute), .read_ready(read_ready), .write_ready(write_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(a_read), .write(a_write), .writedata_left(a_wdl),
        .writedata_right(a_wdr), .sample_valid(a_valid), .sample_data(a_data),
        .sample_ready(ready_a), .overflow(a_ovf), .drop_count(a_drop),
        .xfer_count(a_xfer)
    );

    audio_stream_ctrl #(.WIDTH(24), .DEPTH(8), .DECIM(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sel_right(sel_right),
        .mute(mute), .read_ready(read_ready), .write_ready(write_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read(b_read), .write(b_write), .writedata_left(b_wdl),
        .writedata_right(b_wdr), .sample_valid(b_valid), .sample_data(b_data),
        .sample_ready(ready_b), .overflow(b_ovf), .drop_count(b_drop),
        .xfer_count(b_xfer)
    );

    // Record every sample the DECIM=4 drawer actually consumes.
    always @(negedge clk) begin
        if (mon_en && b_valid && ready_b) begin
            mon_q.push_back(b_data);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; sel_right = 1'b0; mute = 1'b0;
        read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = 24'd0; readdata_right = 24'd0;
        ready_a = 1'b0; ready_b = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({a_read, a_write, a_valid, a_ovf} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {a_read, a_write, a_valid, a_ovf});
        else pass_cnt++;
        total_cnt++;
        if (a_drop !== 8'd0 || a_xfer !== 16'd0)
            $display("FAIL reset_counts: drop %0d xfer %0d want 0 0", a_drop, a_xfer);
        else pass_cnt++;
        total_cnt++;
        if (a_wdl !== 24'd0 || a_wdr !== 24'd0 || a_data !== 24'd0)
            $display("FAIL reset_data: wdl %h wdr %h data %h want 0", a_wdl, a_wdr, a_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        readdata_left = 24'h000123; read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        step(4);
        total_cnt++;
        if (a_read !== 1'b1 || a_valid !== 1'b1)
            $display("FAIL midrst_pre: read %b valid %b want 1 1", a_read, a_valid);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({a_read, a_write, a_valid} !== 3'b000 || a_xfer !== 16'd0)
            $display("FAIL midrst_async: rwv %b xfer %0d want 000 0", {a_read, a_write, a_valid}, a_xfer);
        else pass_cnt++;
        #2 reset_n = 1'b1;
        step(1);
        total_cnt++;
        if (a_read !== 1'b1)
            $display("FAIL midrst_restart: read %b want 1", a_read);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (a_read !== 1'b0 || a_xfer !== 16'd1)
            $display("FAIL midrst_gap: read %b xfer %0d want 0 1", a_read, a_xfer);
        else pass_cnt++;
        enable = 1'b0;
    endtask

    task automatic test_loopback();
        do_reset();
        readdata_left = 24'h000123; readdata_right = 24'h000456;
        read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            total_cnt++;
            if (a_read !== ((i % 3) == 1) || a_write !== ((i % 3) == 1))
                $display("FAIL loop_strobe[%0d]: read %b write %b want %b", i, a_read, a_write, ((i % 3) == 1));
            else pass_cnt++;
            if (i == 1) begin
                total_cnt++;
                if (a_wdl !== 24'h000123 || a_wdr !== 24'h000456)
                    $display("FAIL loop_wdata: %h %h want 000123 000456", a_wdl, a_wdr);
                else pass_cnt++;
            end
            if (i == 3) begin
                total_cnt++;
                if (a_valid !== 1'b1 || a_data !== 24'h000123)
                    $display("FAIL loop_latency: valid %b data %h want 1 000123", a_valid, a_data);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (a_xfer !== 16'd4)
            $display("FAIL loop_xfer_count: got %0d want 4", a_xfer);
        else pass_cnt++;
        enable = 1'b0;
    endtask

    task automatic test_mute();
        do_reset();
        mute = 1'b1; sel_right = 1'b1;
        readdata_right = 24'h7FFFFF; readdata_left = 24'h555555;
        read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        step(1);
        total_cnt++;
        if (a_read !== 1'b1 || a_wdl !== 24'd0 || a_wdr !== 24'd0)
            $display("FAIL mute_wdata: read %b wdl %h wdr %h want 1 0 0", a_read, a_wdl, a_wdr);
        else pass_cnt++;
        enable = 1'b0;
        step(2);
        total_cnt++;
        if (a_valid !== 1'b1 || a_data !== 24'h7FFFFF)
            $display("FAIL mute_fifo: valid %b data %h want 1 7fffff", a_valid, a_data);
        else pass_cnt++;
        total_cnt++;
        if (a_xfer !== 16'd1)
            $display("FAIL mute_xfer: got %0d want 1", a_xfer);
        else pass_cnt++;
        mute = 1'b0; sel_right = 1'b0;
    endtask

    task automatic test_decim();
        logic [23:0] exp_v [3];
        exp_v[0] = 24'd4; exp_v[1] = 24'd8; exp_v[2] = 24'd12;
        do_reset();
        mon_q.delete();
        mon_en = 1'b1; ready_b = 1'b1;
        read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            readdata_left = 24'(k);
            step(3);
        end
        enable = 1'b0;
        step(4);
        mon_en = 1'b0;
        total_cnt++;
        if (mon_q.size() != 3)
            $display("FAIL decim_count: got %0d want 3", mon_q.size());
        else pass_cnt++;
        for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (j >= mon_q.size())
                $display("FAIL decim_sample[%0d]: missing want %0d", j, exp_v[j]);
            else if (mon_q[j] !== exp_v[j])
                $display("FAIL decim_sample[%0d]: got %0d want %0d", j, mon_q[j], exp_v[j]);
            else pass_cnt++;
        end
        ready_b = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            readdata_left = 24'(k);
            step(3);
        end
        enable = 1'b0;
        step(2);
        total_cnt++;
        if (a_ovf !== 1'b1 || a_drop !== 8'd2)
            $display("FAIL ovf_flag: ovf %b drop %0d want 1 2", a_ovf, a_drop);
        else pass_cnt++;
        ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total_cnt++;
            if (a_valid !== 1'b1 || a_data !== 24'(i))
                $display("FAIL ovf_drain[%0d]: valid %b data %0d want 1 %0d", i, a_valid, a_data, i);
            else pass_cnt++;
            step(1);
        end
        ready_a = 1'b0;
        total_cnt++;
        if (a_valid !== 1'b0)
            $display("FAIL ovf_empty: valid %b want 0", a_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int reads;
        do_reset();
        read_ready = 1'b1; write_ready = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            readdata_left = 24'(k);
            step(3);
        end
        readdata_left = 24'd9;
        step(1);
        total_cnt++;
        if (a_read !== 1'b1)
            $display("FAIL b2b_xfer9: read %b want 1", a_read);
        else pass_cnt++;
        step(1);
        ready_a = 1'b1; enable = 1'b0;
        step(1);
        ready_a = 1'b0;
        total_cnt++;
        if (a_drop !== 8'd0 || a_ovf !== 1'b0)
            $display("FAIL b2b_nodrop: drop %0d ovf %b want 0 0", a_drop, a_ovf);
        else pass_cnt++;
        total_cnt++;
        if (a_valid !== 1'b1 || a_data !== 24'd2)
            $display("FAIL b2b_head: valid %b data %0d want 1 2", a_valid, a_data);
        else pass_cnt++;
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (a_read === 1'b1) reads++;
        end
        total_cnt++;
        if (reads != 0 || a_xfer !== 16'd9)
            $display("FAIL b2b_disabled: reads %0d xfer %0d want 0 9", reads, a_xfer);
        else pass_cnt++;
        ready_a = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            total_cnt++;
            if (a_valid !== 1'b1 || a_data !== 24'(i))
                $display("FAIL b2b_drain[%0d]: valid %b data %0d want 1 %0d", i, a_valid, a_data, i);
            else pass_cnt++;
            step(1);
        end
        ready_a = 1'b0;
        total_cnt++;
        if (a_valid !== 1'b0)
            $display("FAIL b2b_empty: valid %b want 0", a_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_xfer();
        test_loopback();
        test_mute();
        test_decim();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
